// File: rtl/denorm_shift_pipe.sv
// denorm_shift_pipe: three-stage pipelined logical right-shifter for 24-bit
// mantissas. It produces the shifted fraction plus guard/round/sticky bits.
// The fraction is extended to 26 bits ({frac, 2'b00}) so that guard and round
// are the two bits below the fraction. Any bit shifted out below ext[0] at
// any stage is ORed into sticky.
//   Stage 1: shift by 16/8   (shamt[4:3])
//   Stage 2: shift by 4/2    (shamt[2:1])
//   Stage 3: shift by 1      (shamt[0]); this stage holds the output registers.
// Each stage has a valid/ready handshake. Bubbles collapse, and the pipeline
// holds up to 3 operands.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_frac, in_shamt     24-bit mantissa, 5-bit right-shift amount
//   out_valid/out_ready   output handshake
//   out_frac              in_frac >> in_shamt
//   out_guard/out_round   first and second bits shifted out
//   out_sticky            OR of all further bits shifted out
module denorm_shift_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_frac,
  input  logic [4:0]  in_shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_frac,
  output logic        out_guard,
  output logic        out_round,
  output logic        out_sticky
);

  // Returns {sticky_of_dropped_bits, v >> n}. The low 26 bits of the
  // double-width shift hold exactly the bits that fell off the bottom.
  function automatic logic [26:0] shr(input logic [25:0] v, input logic [4:0] n);
    logic [51:0] t;
    t = {v, 26'd0} >> n;
    return {|t[25:0], t[51:26]};
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [25:0] s1_ext_q,   s1_ext_d;
  logic        s1_stk_q,   s1_stk_d;
  logic [2:0]  s1_sh_q,    s1_sh_d;

  logic        s2_valid_q, s2_valid_d;
  logic [25:0] s2_ext_q,   s2_ext_d;
  logic        s2_stk_q,   s2_stk_d;
  logic        s2_sh_q,    s2_sh_d;

  logic        s3_valid_q, s3_valid_d;
  logic [23:0] frac_q,     frac_d;
  logic        guard_q,    guard_d;
  logic        round_q,    round_d;
  logic        sticky_q,   sticky_d;

  logic s1_load, s2_load, s3_load;
  logic [26:0] sh1, sh2, sh3;

  // Handshake chain: each stage advances exactly when the next one loads.
  always_comb begin
    s3_load  = s2_valid_q & (~s3_valid_q | out_ready);
    s2_load  = s1_valid_q & (~s2_valid_q | s3_load);
    in_ready = ~s1_valid_q | s2_load;
    s1_load  = in_valid & in_ready;
  end

  always_comb begin
    sh1 = shr({in_frac, 2'b00}, {in_shamt[4:3], 3'b000});
    sh2 = shr(s1_ext_q, {2'b00, s1_sh_q[2:1], 1'b0});
    sh3 = shr(s2_ext_q, {4'b0000, s2_sh_q});
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ext_d   = s1_ext_q;
    s1_stk_d   = s1_stk_q;
    s1_sh_d    = s1_sh_q;
    s2_valid_d = s2_valid_q;
    s2_ext_d   = s2_ext_q;
    s2_stk_d   = s2_stk_q;
    s2_sh_d    = s2_sh_q;
    s3_valid_d = s3_valid_q;
    frac_d     = frac_q;
    guard_d    = guard_q;
    round_d    = round_q;
    sticky_d   = sticky_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_ext_d   = sh1[25:0];
      s1_stk_d   = sh1[26];
      s1_sh_d    = in_shamt[2:0];
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_ext_d   = sh2[25:0];
      s2_stk_d   = s1_stk_q | sh2[26];
      s2_sh_d    = s1_sh_q[0];
    end else if (s3_load) begin
      s2_valid_d = 1'b0;
    end

    if (s3_load) begin
      s3_valid_d = 1'b1;
      frac_d     = sh3[25:2];
      guard_d    = sh3[1];
      round_d    = sh3[0];
      sticky_d   = s2_stk_q | sh3[26];
    end else if (out_ready) begin
      s3_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ext_q   <= '0;
      s1_stk_q   <= 1'b0;
      s1_sh_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_ext_q   <= '0;
      s2_stk_q   <= 1'b0;
      s2_sh_q    <= 1'b0;
      s3_valid_q <= 1'b0;
      frac_q     <= '0;
      guard_q    <= 1'b0;
      round_q    <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ext_q   <= s1_ext_d;
      s1_stk_q   <= s1_stk_d;
      s1_sh_q    <= s1_sh_d;
      s2_valid_q <= s2_valid_d;
      s2_ext_q   <= s2_ext_d;
      s2_stk_q   <= s2_stk_d;
      s2_sh_q    <= s2_sh_d;
      s3_valid_q <= s3_valid_d;
      frac_q     <= frac_d;
      guard_q    <= guard_d;
      round_q    <= round_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid  = s3_valid_q;
  assign out_frac   = frac_q;
  assign out_guard  = guard_q;
  assign out_round  = round_q;
  assign out_sticky = sticky_q;

endmodule

// File: tb/tb_denorm_shift_pipe.sv
// Directed testbench for denorm_shift_pipe with hand-computed expected values.
module tb_denorm_shift_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_frac;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_frac;
  logic        out_guard;
  logic        out_round;
  logic        out_sticky;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  denorm_shift_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_frac    (in_frac),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_frac   (out_frac),
    .out_guard  (out_guard),
    .out_round  (out_round),
    .out_sticky (out_sticky)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_word();
    return {5'd0, out_frac, out_guard, out_round, out_sticky};
  endfunction

  // Sends one operand into an idle pipeline and checks the 3-cycle latency
  // and the result fields.
  task automatic run_op(input string tag, input logic [23:0] f, input logic [4:0] s,
                        input logic [23:0] ef, input logic eg, input logic er, input logic es);
    in_valid  = 1'b1;
    in_frac   = f;
    in_shamt  = s;
    out_ready = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_lat2"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_result"}, res_word(), {5'd0, ef, eg, er, es});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] bp_exp [5];
    int unsigned sent, got, acc_seen;
    logic [23:0] held;

    rst = 1'b1; in_valid = 1'b0; in_frac = '0; in_shamt = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_result", res_word(), 32'd0);
    check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("v_c00001_0",  24'hC00001, 5'd0,  24'hC00001, 1'b0, 1'b0, 1'b0);
    run_op("v_800003_2",  24'h800003, 5'd2,  24'h200000, 1'b1, 1'b1, 1'b0);
    run_op("v_000017_5",  24'h000017, 5'd5,  24'h000000, 1'b1, 1'b0, 1'b1);
    run_op("v_ffffff_24", 24'hFFFFFF, 5'd24, 24'h000000, 1'b1, 1'b1, 1'b1);
    run_op("v_000001_31", 24'h000001, 5'd31, 24'h000000, 1'b0, 1'b0, 1'b1);
    run_op("v_abcdef_8",  24'hABCDEF, 5'd8,  24'h00ABCD, 1'b1, 1'b1, 1'b1);
    run_op("v_abcdef_25", 24'hABCDEF, 5'd25, 24'h000000, 1'b0, 1'b1, 1'b1);
    run_op("v_800000_25", 24'h800000, 5'd25, 24'h000000, 1'b0, 1'b1, 1'b0);
    run_op("v_400000_24", 24'h400000, 5'd24, 24'h000000, 1'b0, 1'b1, 1'b0);
    run_op("v_800000_26", 24'h800000, 5'd26, 24'h000000, 1'b0, 1'b0, 1'b1);
    run_op("v_ffffff_1",  24'hFFFFFF, 5'd1,  24'h7FFFFF, 1'b1, 1'b0, 1'b0);
    run_op("v_000000_31", 24'h000000, 5'd31, 24'h000000, 1'b0, 1'b0, 1'b0);
    run_op("v_123456_19", 24'h123456, 5'd19, 24'h000002, 1'b0, 1'b1, 1'b1);

    // Drain the last result.
    @(posedge clk); #1;

    // Back-pressure: five operands, out_ready low from cycle 2 until cycle 8.
    bp_exp[0] = 24'h800000; bp_exp[1] = 24'h400000; bp_exp[2] = 24'h200000;
    bp_exp[3] = 24'h100000; bp_exp[4] = 24'h080000;
    sent = 0; got = 0; acc_seen = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      out_ready = (cyc < 2) || (cyc >= 8);
      in_valid  = (sent < 5);
      in_frac   = 24'h800000;
      in_shamt  = sent[4:0];
      #1;
      if (cyc == 3) begin
        check_eq("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check_eq("bp_accepted3", sent, 32'd3);
        held = out_frac;
      end
      if (cyc > 3 && cyc < 8) begin
        check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check_eq("bp_hold_frac", {8'd0, out_frac}, {8'd0, held});
        check_eq("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        check_eq("bp_order", {8'd0, out_frac}, {8'd0, bp_exp[got]});
        check_eq("bp_grs", {29'd0, out_guard, out_round, out_sticky}, 32'd0);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("bp_count", got, 32'd5);
    check_eq("bp_first_held", {8'd0, held}, 32'h800000);

    // Reset with two operands in flight.
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_frac = 24'h800000; in_shamt = 5'd0;
    @(posedge clk); #1;
    in_frac = 24'h400000; in_shamt = 5'd1;
    @(posedge clk); #1;
    rst = 1'b1; in_frac = 24'h200000; in_shamt = 5'd2;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check_eq("rst_mid_result", res_word(), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check_eq("rst_mid_no_out", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    run_op("after_rst", 24'hFFFFFF, 5'd1, 24'h7FFFFF, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/denorm_shift_pipe.md
# denorm_shift_pipe

Three-stage pipelined right-shifter for 24-bit mantissas. It produces the shifted fraction plus guard, round and sticky bits for rounding. It is the inverse-direction companion of the leading-zero normaliser in the FP datapath: the normaliser left-shifts to remove leading zeros, and this block right-shifts to align or denormalise operands. Each stage carries a valid/ready handshake, so the block accepts one operand per cycle and stalls cleanly under downstream back-pressure.

## Interface
Parameters:
- none (fixed 24-bit fraction, 5-bit shift amount)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept an operand this cycle
- in_frac  in  24  mantissa to shift
- in_shamt  in  5  right-shift amount, 0..31, all values legal
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result this cycle
- out_frac  out  24  in_frac >> in_shamt
- out_guard  out  1  first bit shifted out
- out_round  out  1  second bit shifted out
- out_sticky  out  1  OR of all remaining bits shifted out

## Operation
- Arithmetic:
  - Extend the fraction to 26 bits as {in_frac, 2'b00} and shift it right logically by in_shamt.
  - Result fields: out_frac = ext[25:2], out_guard = ext[1], out_round = ext[0].
  - out_sticky = OR of every in_frac bit shifted past the round position.
- Boundary values of in_shamt:
  - 24: out_frac 0, guard = in_frac[23], round = in_frac[22], sticky = |in_frac[21:0].
  - 25: out_frac 0, guard 0, round = in_frac[23], sticky = |in_frac[22:0].
  - 26..31: out_frac 0, guard 0, round 0, sticky = |in_frac.
- Stage 1 registers: frac shifted by shamt[4] (16) and shamt[3] (8), sticky accumulated from the bits dropped, residual shamt[2:0], valid.
- Stage 2 registers: shifts by shamt[2] (4) and shamt[1] (2), keeping the 26-bit extended datapath and accumulating sticky.
- Stage 3 (output registers): shift by shamt[0] (1), then split into frac, guard, round and sticky.
- Sticky is an OR of every bit dropped below ext bit 0 at any stage. Bits shifted into the guard and round positions and then shifted further out are also ORed into sticky.
- Flow control, per stage k:
  - Stage k loads when its upstream is valid and (stage k is empty or stage k is advancing).
  - The output stage advances when out_ready is high.
  - in_ready = !s1_valid | s1_advance. This is combinational through the chain from out_ready, which is an accepted path.
- Ordering is strictly FIFO. No operand is dropped or duplicated.
- Capacity is 3 operands.

## Timing
- Latency: an operand accepted in cycle N appears on out_* in cycle N+3 if no stall occurs.
- Throughput: 1 operand per cycle while out_ready is held high.
- Reset (rst high at an edge): all stage valids clear to 0; out_frac, out_guard, out_round and out_sticky reset to 0.
  - out_valid is 0 in the cycle after reset.
  - in_ready is 1 from the first cycle after rst deasserts.
- Reset mid-operation: all in-flight operands are discarded and none is emitted. An input presented in the same cycle as rst is not accepted.
- Stall:
  - With out_ready low and out_valid high, out_* hold stable.
  - Bubbles collapse: an empty stage may fill even while a later stage is stalled.
- in_ready drops only when all three stages are full and out_ready is low.
- Simultaneous accept and emit in one cycle with a full pipeline is legal and keeps occupancy at 3.
- out_* content is don't-care while out_valid is low, except after reset, when it is zero.

## Test plan
- Reset, then in_frac=0xC00001, in_shamt=0 → three cycles later out_valid=1, out_frac=0xC00001, guard/round/sticky = 0/0/0.
- in_frac=0x800003, in_shamt=2 → out_frac=0x200000, guard/round/sticky = 1/1/0.
- in_frac=0x000017, in_shamt=5 → out_frac=0, guard/round/sticky = 1/0/1.
- Boundary amounts:
  - in_frac=0xFFFFFF, in_shamt=24 → out_frac 0, guard/round/sticky = 1/1/1.
  - in_frac=0x000001, in_shamt=31 → out_frac 0, guard/round/sticky = 0/0/1.
- Back-pressure:
  - Stimulus: 5 consecutive operands (shamt 0..4, frac 0x800000) with out_ready low from cycle 2.
  - Required: in_ready falls after 3 operands are held and out_* stay stable. After out_ready rises, results emerge in order: 0x800000, 0x400000, 0x200000, 0x100000, 0x080000.
- Reset with 2 operands in flight → out_valid stays 0 and no result from those operands ever appears. A new operand after reset returns the correct result 3 cycles after acceptance.
